// File: rtl/jtag_ir_dr_chain.sv
// JTAG instruction register, BYPASS/IDCODE/USER data-register chain and TDO mux.
// Optional macro JTAG_TDO_NEGEDGE_EN retimes tdo/tdo_en onto the falling edge of tck.
module jtag_ir_dr_chain #(
    parameter int unsigned          IR_WIDTH   = 4,
    parameter logic [31:0]          IDCODE_VAL = 32'h0BA0_0477,
    parameter logic [IR_WIDTH-1:0]  IDCODE_OP  = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0]  USER_OP    = IR_WIDTH'(4'h2),
    parameter int unsigned          USER_WIDTH = 8
) (
    input  logic                  tck,
    input  logic                  trstn,
    input  logic                  test_logic_reset,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  capture_ir,
    input  logic                  shift_ir,
    input  logic                  update_ir,
    input  logic                  tdi,
    input  logic [USER_WIDTH-1:0] user_din,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir,
    output logic [USER_WIDTH-1:0] user_dout,
    output logic                  user_update
);

    localparam int unsigned ID_WIDTH = 32;
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_ID     = 2'd1,
        SEL_USER   = 2'd2
    } dr_sel_e;

    logic [IR_WIDTH-1:0]   ir_shift;
    logic                  bypass_reg;
    logic [ID_WIDTH-1:0]   id_shift;
    logic [USER_WIDTH-1:0] user_shift;
    dr_sel_e               dr_sel;
    logic                  dr_bit_c;
    logic                  tdo_c;
    logic                  tdo_en_c;

    // Instruction path: capture/shift/update of ir_shift into the active ir
    always_ff @(posedge tck) begin
        if (!trstn) begin
            ir       <= IDCODE_OP;
            ir_shift <= '0;
        end else if (test_logic_reset) begin
            ir       <= IDCODE_OP;
            ir_shift <= '0;
        end else if (capture_ir) begin
            ir_shift <= IR_CAPTURE;
        end else if (shift_ir) begin
            ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        end else if (update_ir) begin
            ir <= ir_shift;
        end
    end

    // DR select follows the registered ir; every unknown opcode falls back to BYPASS
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir == IDCODE_OP) begin
            dr_sel = SEL_ID;
        end else if (ir == USER_OP) begin
            dr_sel = SEL_USER;
        end
    end

    // Data registers: only the selected one captures or shifts, the rest hold
    always_ff @(posedge tck) begin
        if (!trstn) begin
            bypass_reg  <= 1'b0;
            id_shift    <= '0;
            user_shift  <= '0;
            user_dout   <= '0;
            user_update <= 1'b0;
        end else if (test_logic_reset) begin
            bypass_reg  <= 1'b0;
            id_shift    <= '0;
            user_shift  <= '0;
            user_update <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (capture_dr) begin
                case (dr_sel)
                    SEL_ID:   id_shift   <= IDCODE_VAL;
                    SEL_USER: user_shift <= user_din;
                    default:  bypass_reg <= 1'b0;
                endcase
            end else if (shift_dr) begin
                case (dr_sel)
                    SEL_ID:   id_shift   <= {tdi, id_shift[ID_WIDTH-1:1]};
                    SEL_USER: user_shift <= {tdi, user_shift[USER_WIDTH-1:1]};
                    default:  bypass_reg <= tdi;
                endcase
            end else if (update_dr && (dr_sel == SEL_USER)) begin
                user_dout   <= user_shift;
                user_update <= 1'b1;
            end
        end
    end

    // TDO mux: IR scan takes precedence should both shift strobes ever coincide
    always_comb begin
        case (dr_sel)
            SEL_ID:   dr_bit_c = id_shift[0];
            SEL_USER: dr_bit_c = user_shift[0];
            default:  dr_bit_c = bypass_reg;
        endcase
        tdo_c = 1'b0;
        if (shift_ir) begin
            tdo_c = ir_shift[0];
        end else if (shift_dr) begin
            tdo_c = dr_bit_c;
        end
        tdo_en_c = shift_ir | shift_dr;
    end

`ifdef JTAG_TDO_NEGEDGE_EN
    // Falling-edge launch gives the board half a cycle of hold on TDO
    always_ff @(negedge tck) begin
        if (!trstn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= tdo_c;
            tdo_en <= tdo_en_c;
        end
    end
`else
    assign tdo    = tdo_c;
    assign tdo_en = tdo_en_c;
`endif

endmodule

// File: tb/tb_jtag_ir_dr_chain.sv
// Directed self-checking bench for jtag_ir_dr_chain (default combinational TDO build).
module tb_jtag_ir_dr_chain;

    localparam int unsigned IR_WIDTH   = 4;
    localparam int unsigned USER_WIDTH = 8;
    localparam logic [31:0] IDCODE     = 32'h0BA0_0477;

    logic                  tck = 1'b0;
    logic                  trstn;
    logic                  test_logic_reset;
    logic                  capture_dr, shift_dr, update_dr;
    logic                  capture_ir, shift_ir, update_ir;
    logic                  tdi;
    logic [USER_WIDTH-1:0] user_din;
    logic                  tdo, tdo_en;
    logic [IR_WIDTH-1:0]   ir;
    logic [USER_WIDTH-1:0] user_dout;
    logic                  user_update;

    int n_cmp = 0;
    int n_err = 0;

    jtag_ir_dr_chain dut (
        .tck              (tck),
        .trstn            (trstn),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir),
        .tdi              (tdi),
        .user_din         (user_din),
        .tdo              (tdo),
        .tdo_en           (tdo_en),
        .ir               (ir),
        .user_dout        (user_dout),
        .user_update      (user_update)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; one rising edge is consumed
    task automatic tick();
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic load_ir(input logic [IR_WIDTH-1:0] val);
        capture_ir = 1'b1;
        tick();
        capture_ir = 1'b0;
        shift_ir   = 1'b1;
        for (int i = 0; i < int'(IR_WIDTH); i++) begin
            tdi = val[i];
            #1;
            check($sformatf("ir_tdo[%0d]", i), 32'(tdo), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end
        shift_ir  = 1'b0;
        update_ir = 1'b1;
        tick();
        update_ir = 1'b0;
        check("ir_after_update", 32'(ir), 32'(val));
    endtask

    task automatic shift_dr_bits(input string tag, input logic [31:0] din,
                                 input logic [31:0] exp, input int n);
        shift_dr = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            #1;
            check($sformatf("%s_tdo[%0d]", tag, i), 32'(tdo), 32'(exp[i]));
            check($sformatf("%s_en[%0d]", tag, i), 32'(tdo_en), 32'd1);
            tick();
        end
        shift_dr = 1'b0;
    endtask

    task automatic capture();
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
    endtask

    task automatic bypass_run(input logic [IR_WIDTH-1:0] op);
        load_ir(op);
        capture();
        shift_dr_bits($sformatf("byp%0h", op), 32'b1101, 32'b1010, 4);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        check($sformatf("byp%0h_no_update", op), 32'(user_update), 32'd0);
        check($sformatf("byp%0h_dout_hold", op), 32'(user_dout), 32'h3C);
    endtask

    initial begin
        trstn = 1'b0; test_logic_reset = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
        tdi = 1'b0; user_din = '0;
        @(negedge tck);
        tick();
        trstn = 1'b1;

        // Random strobe traffic, then a single reset edge
        for (int i = 0; i < 24; i++) begin
            {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir} = 6'($urandom);
            test_logic_reset = 1'b0;
            tdi      = 1'($urandom);
            user_din = 8'($urandom);
            tick();
        end
        {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir} = '0;
        trstn = 1'b0;
        tick();
        trstn = 1'b1;
        #1;
        check("rst_ir", 32'(ir), 32'h1);
        check("rst_dout", 32'(user_dout), 32'h0);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_update", 32'(user_update), 32'd0);
        check("idle_tdo", 32'(tdo), 32'd0);

        // IDCODE read, then one extra shift past the end
        capture();
        shift_dr_bits("idcode", 32'h0, IDCODE, 32);
        shift_dr_bits("id33", 32'h0, 32'h0, 1);

        // IR load to USER with tdi 0,1,0,0
        load_ir(4'h2);

        // USER capture/shift/update
        user_din = 8'hA5;
        capture();
        shift_dr_bits("user", 32'h3C, 32'hA5, 8);
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        check("user_dout", 32'(user_dout), 32'h3C);
        check("user_update_hi", 32'(user_update), 32'd1);
        tick();
        check("user_update_lo", 32'(user_update), 32'd0);

        // BYPASS for all-ones and an unassigned opcode
        bypass_run(4'hF);
        bypass_run(4'h7);

        // Test-Logic-Reset in the middle of a USER scan
        load_ir(4'h2);
        user_din = 8'hFF;
        capture();
        shift_dr_bits("pre_tlr", 32'h0, 32'h7, 3);
        shift_dr         = 1'b1;
        test_logic_reset = 1'b1;
        tick();
        shift_dr         = 1'b0;
        test_logic_reset = 1'b0;
        check("tlr_ir", 32'(ir), 32'h1);
        check("tlr_dout_hold", 32'(user_dout), 32'h3C);
        check("tlr_update", 32'(user_update), 32'd0);
        // user_shift must read back as zeros without a fresh capture
        load_ir(4'h2);
        shift_dr_bits("tlr_cleared", 32'h0, 32'h0, 8);
        trstn = 1'b0;
        tick();
        trstn = 1'b1;
        check("trst_dout", 32'(user_dout), 32'h0);
        check("trst_ir", 32'(ir), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_ir_dr_chain.md
Name: jtag_ir_dr_chain

Overview:
- Instruction register, data-register chain and TDO mux for the JTAG TAP.
- Sits directly downstream of the TAP controller and consumes its capture/shift/update strobes plus a test-logic-reset indication.
- Provides BYPASS, IDCODE and one USER data register with parallel in/out to core logic.

Parameters:
- IR_WIDTH, 4, instruction register width (minimum 2).
- IDCODE_VAL, 32'h0BA0_0477, IDCODE value; bit 0 must be 1.
- IDCODE_OP, 4'h1, IDCODE opcode; also the reset instruction.
- USER_OP, 4'h2, USER data-register opcode.
- USER_WIDTH, 8, USER data-register width.

Ports:
- tck  in  1  TCK; only clock. All state updates on the rising edge unless the optional feature is enabled.
- trstn  in  1  reset, synchronous, active-low, sampled on rising tck.
- test_logic_reset  in  1  TAP is in Test-Logic-Reset.
- capture_dr / shift_dr / update_dr  in  1 each  TAP DR strobes.
- capture_ir / shift_ir / update_ir  in  1 each  TAP IR strobes.
- tdi  in  1  serial data in.
- user_din  in  USER_WIDTH  parallel capture value for the USER register.
- tdo  out  1  serial data out.
- tdo_en  out  1  TDO output enable.
- ir  out  IR_WIDTH  active instruction.
- user_dout  out  USER_WIDTH  USER register parallel output.
- user_update  out  1  one-cycle pulse on a USER update.

Behaviour:
- Strobes reflect the TAP state before the current rising edge. The action for each strobe takes effect at that edge.
- trstn=0 at a rising edge:
  - ir <= IDCODE_OP.
  - ir_shift, bypass_reg, id_shift, user_shift <= 0.
  - user_dout <= 0, user_update <= 0.
- test_logic_reset=1 with trstn=1:
  - ir <= IDCODE_OP.
  - Shift registers cleared.
  - user_dout holds its value; user_update <= 0.
- IR path:
  - capture_ir: ir_shift <= {0...,2'b01}.
  - shift_ir: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}, LSB first.
  - update_ir: ir <= ir_shift.
- DR select is decoded from ir:
  - IDCODE_OP selects id_shift (32 bits).
  - USER_OP selects user_shift (USER_WIDTH bits).
  - All-ones and every other opcode select bypass_reg (1 bit).
- DR capture:
  - id_shift <= IDCODE_VAL.
  - user_shift <= user_din.
  - bypass_reg <= 0.
- DR shift: the selected register shifts right; tdi enters the MSB.
- DR update:
  - Acts only when ir==USER_OP: user_dout <= user_shift, and user_update is 1 for exactly the next cycle.
  - Otherwise no effect; user_update=0.
- Unselected DRs hold their value.
- tdo (combinational):
  - ir_shift[0] when shift_ir.
  - Selected DR bit 0 when shift_dr.
  - 0 otherwise.
- tdo_en = shift_ir | shift_dr.
- Priority when strobes coincide, applied separately per group: trstn > test_logic_reset > capture > shift > update.
- An ir change mid-DR-scan cannot occur by TAP construction. If it does, the DR select follows the new ir on the next edge.
- Widths: all shifts are exactly register-width. No wrap: bits shifted past bit 0 are discarded.

Optional Feature:
- Macro: JTAG_TDO_NEGEDGE_EN.
- Defined:
  - tdo and tdo_en are registered on the falling edge of tck from the combinational values above.
  - Both are synchronously cleared to 0 when trstn=0 at that falling edge.
  - Output changes half a cycle after the rising edge, per IEEE 1149.1 timing.
- Undefined: tdo and tdo_en are purely combinational as above. No falling-edge logic exists.

Test Plan:
- Reset: trstn=0 for 1 edge after random traffic -> ir=4'h1, user_dout=8'h00, tdo_en=0, user_update=0.
- IDCODE read after reset: capture_dr 1 cycle, then shift_dr 32 cycles with tdi=0 -> tdo emits 0x0BA00477 LSB first (first bit 1) and tdo_en=1 throughout. A 33rd shift yields tdo=0.
- IR load: capture_ir, then shift_ir 4 cycles with tdi=0,1,0,0 -> tdo=1,0,0,0. After update_ir: ir=4'h2.
- USER: ir=4'h2, user_din=8'hA5, capture_dr, shift_dr 8 cycles shifting in 8'h3C LSB first -> tdo=1,0,1,0,0,1,0,1. After update_dr: user_dout=8'h3C, user_update=1 for one cycle only.
- Bypass: ir=4'hF, then separately ir=4'h7. capture_dr, shift tdi=1,0,1,1 -> tdo=0,1,0,1 (one-bit delay) in both cases. user_dout unchanged.
- Mid-scan TLR: during a USER shift, assert test_logic_reset 1 cycle -> ir=4'h1, user_shift=0, user_dout retains 8'h3C. trstn=0 then clears user_dout to 8'h00.
